// File: rtl/isp_awb_pkg.sv
// Shared constants, Bayer site codes and FSM encoding for the AWB gain controller.
package isp_awb_pkg;

  localparam logic [7:0] GAIN_UNITY = 8'h10;
  localparam logic [7:0] GAIN_MAX   = 8'hFF;
  localparam int         GAIN_FRAC  = 4;

  // Site code is {row[0], col[0]}
  localparam logic [1:0] SITE_B  = 2'b00;
  localparam logic [1:0] SITE_G0 = 2'b01;
  localparam logic [1:0] SITE_G1 = 2'b10;
  localparam logic [1:0] SITE_R  = 2'b11;

  // One overflow-check cycle followed by eight quotient-bit cycles
  localparam int DIV_CYCLES = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV_R  = 2'd1,
    ST_DIV_B  = 2'd2,
    ST_UPDATE = 2'd3
  } awb_state_t;

endpackage

// File: rtl/isp_awb_div.sv
// Sequential restoring divider producing an 8-bit quotient that saturates at
// GAIN_MAX. The start cycle performs the overflow check; the following eight
// cycles resolve one quotient bit each, MSB first. done is high in the last
// cycle and quotient then carries the final result.
module isp_awb_div
  import isp_awb_pkg::*;
#(
  parameter int NUM_W = 35,
  parameter int DEN_W = 32
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             done,
  output logic [7:0]       quotient
);

  // Wide enough to hold divisor<<8; numerator must not exceed this width
  localparam int         EXT_W = DEN_W + 8;
  localparam logic [3:0] STEPS = 4'(DIV_CYCLES - 1);

  logic [EXT_W-1:0] rem, rem_nxt, den_sh;
  logic [DEN_W-1:0] den;
  logic [3:0]       cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       q, q_nxt;
  logic             sat, sat_chk;

  assign sat_chk  = (divisor == '0) || (EXT_W'(numerator) >= {divisor, 8'h00});
  assign bit_idx  = 3'(cnt - 4'd1);
  assign den_sh   = EXT_W'(den) << bit_idx;
  assign done     = (cnt == 4'd1);
  assign quotient = q_nxt;

  // One restoring step for the bit selected by the down-counter
  always_comb begin
    rem_nxt = rem;
    q_nxt   = q;
    if ((cnt != 4'd0) && !sat && (rem >= den_sh)) begin
      rem_nxt        = rem - den_sh;
      q_nxt[bit_idx] = 1'b1;
    end
  end

  // Load operands on start, then step until the counter reaches zero
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      rem <= '0;
      den <= '0;
      q   <= 8'h00;
      sat <= 1'b0;
    end else if (start) begin
      cnt <= STEPS;
      rem <= EXT_W'(numerator);
      den <= divisor;
      q   <= sat_chk ? GAIN_MAX : 8'h00;
      sat <= sat_chk;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      rem <= rem_nxt;
      q   <= q_nxt;
    end
  end

endmodule

// File: rtl/isp_awb_gain_ctrl.sv
// Gray-world AWB controller: accumulates Bayer channel sums per frame,
// divides G by R and G by B at frame end, and publishes Q4.4 gains with a
// one-cycle update strobe.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | accumulating, waiting for frame end
//   ST_DIV_R  | dividing sum_g*8 by sum_r (9 cycles)
//   ST_DIV_B  | dividing sum_g*8 by sum_b (9 cycles)
//   ST_UPDATE | new gains visible, gain_upd high for one cycle
module isp_awb_gain_ctrl
  import isp_awb_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1936,
  parameter int HEIGHT = 1088,
  parameter int SUM_W  = 32
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            data_valid,
  input  logic [BITS-1:0] in_raw,
  input  logic            awb_en,
  output logic [7:0]      gain_r,
  output logic [7:0]      gain_g,
  output logic [7:0]      gain_b,
  output logic            gain_upd,
  output logic            busy,
  output logic            overrun
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // Two G sites per quad, so G*8/R equals (G_avg/R_avg) in Q4.4
  localparam int NUM_W = SUM_W + GAIN_FRAC - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last, row_last, frame_end;
  logic [1:0]       site;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [SUM_W-1:0] add_r, add_g, add_b;
  logic [SUM_W-1:0] snap_r, snap_g, snap_b;
  awb_state_t       state, state_nxt;
  logic             launch;
  logic [7:0]       pend_r;
  logic             div_done;
  logic [7:0]       div_quot;
  logic [NUM_W-1:0] div_num;
  logic [SUM_W-1:0] div_den;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [BITS-1:0]  b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W + 1)'(b);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  assign frame_end = data_valid && col_last && row_last;
  assign site      = {row[0], col[0]};
  assign busy      = (state == ST_DIV_R) || (state == ST_DIV_B);
  assign gain_upd  = (state == ST_UPDATE);
  assign gain_g    = GAIN_UNITY;
  assign div_num   = NUM_W'(snap_g) << (GAIN_FRAC - 1);
  assign div_den   = (state == ST_DIV_B) ? snap_b : snap_r;

  // Raster position; frozen while data_valid is low
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (data_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Channel sums including the current pixel
  always_comb begin
    add_r = sum_r;
    add_g = sum_g;
    add_b = sum_b;
    if (data_valid) begin
      case (site)
        SITE_B:           add_b = sat_add(sum_b, in_raw);
        SITE_G0, SITE_G1: add_g = sat_add(sum_g, in_raw);
        SITE_R:           add_r = sat_add(sum_r, in_raw);
      endcase
    end
  end

  // Accumulate; at frame end hand the complete sums to the snapshots unless
  // a division is still using them
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      sum_r  <= '0;
      sum_g  <= '0;
      sum_b  <= '0;
      snap_r <= '0;
      snap_g <= '0;
      snap_b <= '0;
    end else if (frame_end) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
      if (!busy) begin
        snap_r <= add_r;
        snap_g <= add_g;
        snap_b <= add_b;
      end
    end else begin
      sum_r <= add_r;
      sum_g <= add_g;
      sum_b <= add_b;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_end) state_nxt = awb_en ? ST_DIV_R : ST_UPDATE;
      ST_DIV_R:  if (div_done) state_nxt = ST_DIV_B;
      ST_DIV_B:  if (div_done) state_nxt = ST_UPDATE;
      ST_UPDATE: begin
        if (frame_end) state_nxt = awb_en ? ST_DIV_R : ST_UPDATE;
        else           state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register, divider launch, gain publication and overrun flag
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      launch  <= 1'b0;
      pend_r  <= GAIN_UNITY;
      gain_r  <= GAIN_UNITY;
      gain_b  <= GAIN_UNITY;
      overrun <= 1'b0;
    end else begin
      state  <= state_nxt;
      launch <= (state_nxt != state) &&
                ((state_nxt == ST_DIV_R) || (state_nxt == ST_DIV_B));
      if ((state == ST_DIV_R) && div_done) pend_r <= div_quot;
      if (state_nxt == ST_UPDATE) begin
        if (state == ST_DIV_B) begin
          gain_r <= pend_r;
          gain_b <= div_quot;
        end else begin
          gain_r <= GAIN_UNITY;
          gain_b <= GAIN_UNITY;
        end
      end
      if (frame_end && busy) overrun <= 1'b1;
    end
  end

  isp_awb_div #(
    .NUM_W(NUM_W),
    .DEN_W(SUM_W)
  ) u_div (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .start     (launch),
    .numerator (div_num),
    .divisor   (div_den),
    .done      (div_done),
    .quotient  (div_quot)
  );

endmodule
